// File: rtl/fx2_fifo_reader.sv
// ---------------------------------------------------------------------------
// fx2_fifo_reader
// Pulls bytes from one Cypress FX2 slave FIFO (the OUT endpoint) over the
// shared FD bus and packs them, little-endian, into 32-bit words that are
// handed downstream through a small output buffer. Each bus ownership burst
// moves exactly one word: IDLE -> ADDR -> OE -> READ (4 bytes) -> RELEASE.
//
// Ports
//   clk          IFCLK, all logic on the rising edge
//   reset        synchronous, active-high
//   enable       allows a new burst to start (looked at in IDLE only)
//   flush        one-cycle pulse, drops the partial word and buffered words
//   fd_in        FX2 FD bus as seen by the FPGA
//   flagn_empty  FX2 empty flag of the addressed FIFO, active-low
//   bus_req      request for FD/FIFOADR ownership
//   bus_gnt      ownership grant from the bus arbiter
//   fifoadr      FX2 FIFO address (constant, never glitches)
//   sloen        FX2 SLOE, active-low
//   slrdn        FX2 SLRD, active-low
//   out_data     head word of the output buffer (byte 0 in [7:0])
//   out_valid    out_data holds a word
//   out_ready    downstream takes the word when out_valid is also high
//   busy         high whenever the reader is not IDLE
// ---------------------------------------------------------------------------
module fx2_fifo_reader #(
   parameter logic [1:0] FIFO_ADDR  = 2'b01,
   parameter int         OBUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        flush,
   input  logic [7:0]  fd_in,
   input  logic        flagn_empty,
   output logic        bus_req,
   input  logic        bus_gnt,
   output logic [1:0]  fifoadr,
   output logic        sloen,
   output logic        slrdn,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy
);

   localparam int PTR_W = $clog2(OBUF_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] ADDR    = 3'd1;
   localparam logic [2:0] OE      = 3'd2;
   localparam logic [2:0] READ    = 3'd3;
   localparam logic [2:0] RELEASE = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [1:0]       byteCnt_q, byteCnt_d;
   logic [23:0]      bytes_q, bytes_d;
   logic [31:0]      mem_q [OBUF_DEPTH];
   logic [PTR_W-1:0] rdPtr_q, wrPtr_q;
   logic [CNT_W-1:0] count_q;

   logic obufEmpty, obufFull, pop, push;
   logic wordCompleting, roomForWord, accept;

   // Output buffer status and the downstream handshake.
   assign obufEmpty = (count_q == '0);
   assign obufFull  = (count_q == CNT_W'(OBUF_DEPTH));
   assign pop       = ~obufEmpty & out_ready;

   // A byte is only strobed out of the FX2 when it is present and, if it
   // finishes a word, the buffer can take that word this very edge (a pop
   // on the same edge frees the slot). Bursts only start with a free slot,
   // so this normally never stalls, but it guarantees no overwrite.
   assign wordCompleting = (byteCnt_q == 2'd3);
   assign roomForWord    = ~obufFull | pop;
   assign accept         = (state_q == READ) & flagn_empty &
                           (~wordCompleting | roomForWord);
   assign push           = accept & wordCompleting & ~flush;

   // FX2 strobes and bus ownership are pure decodes of the registered state.
   assign fifoadr   = FIFO_ADDR;
   assign sloen     = ~((state_q == OE) | (state_q == READ));
   assign slrdn     = ~accept;
   assign bus_req   = (state_q != IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = ~obufEmpty;
   assign out_data  = obufEmpty ? 32'h0 : mem_q[rdPtr_q];

   // Burst sequencing and byte-lane packing. Byte 3 is never stored here:
   // it goes straight into the output buffer together with lanes 0..2.
   // A flush wins over everything, including a word completing this edge.
   always_comb begin
      state_d   = state_q;
      byteCnt_d = byteCnt_q;
      bytes_d   = bytes_q;
      case (state_q)
         IDLE: begin
            if (enable & flagn_empty & ~obufFull & ~flush) begin
               state_d = ADDR;
            end
         end
         ADDR: begin
            if (bus_gnt) begin
               state_d = OE;
            end
         end
         OE: begin
            state_d = READ;
         end
         READ: begin
            if (accept) begin
               byteCnt_d = byteCnt_q + 2'd1;
               case (byteCnt_q)
                  2'd0:    bytes_d[7:0]   = fd_in;
                  2'd1:    bytes_d[15:8]  = fd_in;
                  2'd2:    bytes_d[23:16] = fd_in;
                  default: state_d        = RELEASE;
               endcase
            end
         end
         RELEASE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (flush) begin
         byteCnt_d = 2'd0;
         bytes_d   = 24'h0;
         if ((state_q == ADDR) | (state_q == OE) | (state_q == READ)) begin
            state_d = RELEASE;
         end else begin
            state_d = IDLE;
         end
      end
   end

   // State, byte assembly and buffer bookkeeping. Reset drops straight to
   // IDLE without a RELEASE cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         byteCnt_q <= 2'd0;
         bytes_q   <= 24'h0;
         rdPtr_q   <= '0;
         wrPtr_q   <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         byteCnt_q <= byteCnt_d;
         bytes_q   <= bytes_d;
         if (flush) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
         end else begin
            if (push) begin
               wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (pop) begin
               rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            case ({push, pop})
               2'b10:   count_q <= count_q + CNT_W'(1);
               2'b01:   count_q <= count_q - CNT_W'(1);
               default: count_q <= count_q;
            endcase
         end
      end
   end

   // Buffer storage; contents are don't-care while the slot is empty, so
   // no reset is needed here.
   always_ff @(posedge clk) begin
      if (push & ~reset) begin
         mem_q[wrPtr_q] <= {fd_in, bytes_q};
      end
   end

endmodule

// File: tb/tb_fx2_fifo_reader.sv
// ---------------------------------------------------------------------------
// tb_fx2_fifo_reader
// Directed bench for fx2_fifo_reader. A small FX2 model serves bytes from a
// queue whenever SLRD is low at a rising edge. Stimulus pushes the words it
// expects to see into a scoreboard; an independent monitor pops and compares
// on every out_valid & out_ready handshake.
// ---------------------------------------------------------------------------
module tb_fx2_fifo_reader;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        flush;
   logic [7:0]  fd_in;
   logic        flagn_empty;
   logic        bus_req;
   logic        bus_gnt;
   logic [1:0]  fifoadr;
   logic        sloen;
   logic        slrdn;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   logic [31:0] expQ[$];
   logic [7:0]  fx2Q[$];

   always #5 clk = ~clk;

   fx2_fifo_reader #(.FIFO_ADDR(2'b01), .OBUF_DEPTH(2)) dut (
      .clk(clk), .reset(reset), .enable(enable), .flush(flush),
      .fd_in(fd_in), .flagn_empty(flagn_empty), .bus_req(bus_req),
      .bus_gnt(bus_gnt), .fifoadr(fifoadr), .sloen(sloen), .slrdn(slrdn),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy)
   );

   // FX2 model: a byte leaves the FIFO on a rising edge with SLRD low, and
   // FD / EMPTY# settle shortly after the edge.
   initial begin
      fd_in       = 8'h00;
      flagn_empty = 1'b0;
      forever begin
         @(posedge clk);
         if (slrdn === 1'b0 && fx2Q.size() > 0) begin
            fx2Q.delete(0);
         end
         #2;
         fd_in       = (fx2Q.size() > 0) ? fx2Q[0] : 8'h00;
         flagn_empty = (fx2Q.size() > 0);
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
      end
   endtask

   // Monitor: every accepted word is compared with the oldest expectation.
   always @(negedge clk) begin
      logic [31:0] expWord;
      if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_word", out_data, 32'hxxxx_xxxx);
         end else begin
            expWord = expQ.pop_front();
            checkOutput("word", out_data, expWord);
         end
      end
   end

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Queue four FX2 bytes; optionally record the word the monitor must see.
   task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [7:0] b3,
                                input bit expectWord);
      fx2Q.push_back(b0);
      fx2Q.push_back(b1);
      fx2Q.push_back(b2);
      fx2Q.push_back(b3);
      if (expectWord) begin
         expQ.push_back({b3, b2, b1, b0});
      end
   endtask

   task automatic waitFx2Drained(input string name, input int budget);
      int n = 0;
      while (fx2Q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, {31'd0, n >= budget}, 32'd0);
   endtask

   task automatic waitIdle(input string name, input int budget);
      int n = 0;
      @(negedge clk);
      while (!(busy === 1'b0 && fx2Q.size() == 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, {31'd0, n >= budget}, 32'd0);
   endtask

   task automatic waitCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
      end
   endtask

   initial begin
      int idx;
      int busyCnt;
      int reqCnt;
      int lowCnt;
      int sloenLow;
      int firstLow;
      int lastLow;
      int validIdx;
      int bad;
      int n;

      reset     = 1'b1;
      enable    = 1'b0;
      flush     = 1'b0;
      bus_gnt   = 1'b1;
      out_ready = 1'b1;

      // Reset state.
      repeat (3) stepCycle();
      @(negedge clk);
      checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst_out_data", out_data, 32'd0);
      checkOutput("rst_bus_req", {31'd0, bus_req}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_sloen", {31'd0, sloen}, 32'd1);
      checkOutput("rst_slrdn", {31'd0, slrdn}, 32'd1);
      checkOutput("rst_fifoadr", {30'd0, fifoadr}, 32'd1);
      stepCycle();
      reset  = 1'b0;
      enable = 1'b1;

      // Basic burst: timing of strobes, bus request and output latency.
      stepCycle();
      applyStimulus(8'h11, 8'h22, 8'h33, 8'h44, 1'b1);
      busyCnt = 0; reqCnt = 0; lowCnt = 0; sloenLow = 0;
      firstLow = -1; lastLow = -1; validIdx = -1; bad = 0;
      for (idx = 0; idx < 20; idx++) begin
         @(negedge clk);
         if (busy) busyCnt++;
         if (bus_req) reqCnt++;
         if (!sloen) sloenLow++;
         if (fifoadr !== 2'b01) bad++;
         if (!slrdn) begin
            lowCnt++;
            if (firstLow < 0) firstLow = idx;
            lastLow = idx;
         end
         if (out_valid && validIdx < 0) validIdx = idx;
      end
      checkOutput("burst_busy_cycles", busyCnt, 32'd7);
      checkOutput("burst_req_cycles", reqCnt, 32'd7);
      checkOutput("burst_slrd_low", lowCnt, 32'd4);
      checkOutput("burst_slrd_contig", lastLow - firstLow, 32'd3);
      checkOutput("burst_sloe_low", sloenLow, 32'd5);
      checkOutput("burst_latency", validIdx, lastLow + 1);
      checkOutput("burst_fifoadr", bad, 32'd0);

      // FX2 runs empty after byte 0 for five cycles, then the word resumes.
      stepCycle();
      fx2Q.push_back(8'h55);
      expQ.push_back(32'h8877_6655);
      waitFx2Drained("stall_first_byte_timeout", 30);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (slrdn !== 1'b1 || busy !== 1'b1) bad++;
      end
      checkOutput("stall_slrd_high", bad, 32'd0);
      stepCycle();
      fx2Q.push_back(8'h66);
      fx2Q.push_back(8'h77);
      fx2Q.push_back(8'h88);
      waitIdle("stall_resume_timeout", 40);

      // Back-pressure: two words buffered, third burst waits in IDLE.
      stepCycle();
      out_ready = 1'b0;
      applyStimulus(8'h01, 8'h02, 8'h03, 8'h04, 1'b1);
      applyStimulus(8'h05, 8'h06, 8'h07, 8'h08, 1'b1);
      applyStimulus(8'h09, 8'h0A, 8'h0B, 8'h0C, 1'b1);
      waitCycles(40);
      checkOutput("full_idle", {31'd0, busy}, 32'd0);
      checkOutput("full_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("full_fx2_left", fx2Q.size(), 32'd4);
      stepCycle();
      out_ready = 1'b1;
      stepCycle();
      out_ready = 1'b0;
      waitCycles(20);
      checkOutput("full_resumed", fx2Q.size(), 32'd0);
      checkOutput("full_resumed_idle", {31'd0, busy}, 32'd0);
      stepCycle();
      out_ready = 1'b1;
      waitCycles(5);
      checkOutput("full_drained", {31'd0, out_valid}, 32'd0);

      // Grant withheld: parked in ADDR with strobes high, then proceeds.
      stepCycle();
      bus_gnt = 1'b0;
      applyStimulus(8'hA1, 8'hA2, 8'hA3, 8'hA4, 1'b1);
      n = 0;
      @(negedge clk);
      while (busy !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("gnt_start_timeout", {31'd0, n >= 20}, 32'd0);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (sloen !== 1'b1 || slrdn !== 1'b1 || bus_req !== 1'b1 || busy !== 1'b1) bad++;
         @(negedge clk);
      end
      checkOutput("gnt_wait_addr", bad, 32'd0);
      checkOutput("gnt_no_bytes", fx2Q.size(), 32'd4);
      stepCycle();
      bus_gnt = 1'b1;
      waitIdle("gnt_done_timeout", 40);

      // Flush with one word buffered and two bytes of a partial word.
      stepCycle();
      out_ready = 1'b0;
      applyStimulus(8'hB1, 8'hB2, 8'hB3, 8'hB4, 1'b0);
      waitIdle("flush_fill_timeout", 40);
      checkOutput("flush_pre_valid", {31'd0, out_valid}, 32'd1);
      stepCycle();
      fx2Q.push_back(8'hC1);
      fx2Q.push_back(8'hC2);
      waitFx2Drained("flush_partial_timeout", 30);
      waitCycles(2);
      checkOutput("flush_pre_busy", {31'd0, busy}, 32'd1);
      stepCycle();
      flush = 1'b1;
      stepCycle();
      flush = 1'b0;
      @(negedge clk);
      checkOutput("flush_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("flush_release_busy", {31'd0, busy}, 32'd1);
      checkOutput("flush_release_sloe", {31'd0, sloen}, 32'd1);
      @(negedge clk);
      checkOutput("flush_idle", {31'd0, busy}, 32'd0);
      stepCycle();
      out_ready = 1'b1;
      applyStimulus(8'hD1, 8'hD2, 8'hD3, 8'hD4, 1'b1);
      waitIdle("flush_next_timeout", 40);

      // Reset in READ after byte 0, with a word buffered.
      stepCycle();
      out_ready = 1'b0;
      applyStimulus(8'hF1, 8'hF2, 8'hF3, 8'hF4, 1'b0);
      waitIdle("rstmid_fill_timeout", 40);
      stepCycle();
      fx2Q.push_back(8'hE1);
      waitFx2Drained("rstmid_byte_timeout", 30);
      waitCycles(1);
      stepCycle();
      reset = 1'b1;
      stepCycle();
      reset = 1'b0;
      @(negedge clk);
      checkOutput("rstmid_sloen", {31'd0, sloen}, 32'd1);
      checkOutput("rstmid_slrdn", {31'd0, slrdn}, 32'd1);
      checkOutput("rstmid_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rstmid_busy", {31'd0, busy}, 32'd0);
      stepCycle();
      out_ready = 1'b1;
      applyStimulus(8'h5A, 8'hA5, 8'h3C, 8'hC3, 1'b1);
      waitIdle("rstmid_next_timeout", 40);

      waitCycles(4);
      checkOutput("scoreboard_drained", expQ.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
